// File: rtl/sb_pkg.sv
// Shared definitions for the line follower: turn command codes and FSM states.
package sb_pkg;

    // Turn command codes consumed by the motor-control stage.
    localparam logic [2:0] TURN_STOP    = 3'b000;
    localparam logic [2:0] TURN_FWD     = 3'b001;
    localparam logic [2:0] TURN_LEFT    = 3'b010;
    localparam logic [2:0] TURN_RIGHT   = 3'b011;
    localparam logic [2:0] TURN_EXTREME = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACK,
        ST_NODE,
        ST_SEARCH,
        ST_HALT
    } fsm_state_t;

    // Steering for an accepted pattern while tracking. 111 and 000 are
    // handled by the FSM itself; 101 (and anything unexpected) keeps the
    // current command.
    function automatic logic [2:0] track_turn(input logic [2:0] pattern,
                                              input logic [2:0] prev);
        logic [2:0] result;
        case (pattern)
            3'b010:         result = TURN_FWD;
            3'b110, 3'b100: result = TURN_LEFT;
            3'b011, 3'b001: result = TURN_RIGHT;
            default:        result = prev;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/line_sensor_debounce.sv
// Three-channel hysteresis classifier followed by a pattern debouncer.
// Produces the accepted {L,C,R} pattern and a one-cycle acc strobe the
// cycle after the sample that completed the debounce run.
module line_sensor_debounce
    import sb_pkg::*;
#(
    parameter int ADC_W    = 12,
    parameter int THRESH   = 1500,
    parameter int HYST     = 64,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] adc_l,
    input  logic [ADC_W-1:0] adc_c,
    input  logic [ADC_W-1:0] adc_r,
    output logic [2:0]       accepted,
    output logic             acc
);

    // Band edges are clamped to the representable sample range so that
    // extreme parameter choices still produce a usable classifier.
    localparam int MAX_CODE = (1 << ADC_W) - 1;
    localparam int HI_INT   = ((THRESH + HYST) > MAX_CODE) ? MAX_CODE : (THRESH + HYST);
    localparam int LO_INT   = (THRESH > HYST) ? (THRESH - HYST) : 0;
    localparam logic [ADC_W:0] HI_LVL = HI_INT[ADC_W:0];
    localparam logic [ADC_W:0] LO_LVL = LO_INT[ADC_W:0];
    localparam logic [3:0]     DB_LVL = 4'(DEBOUNCE);

    logic [ADC_W-1:0] adc_arr [3];
    logic [2:0]       cls_q;
    logic [2:0]       cls_d;
    logic [2:0]       cand_q;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [2:0]       accepted_q;
    logic             acc_q;
    logic             same_pat;
    logic             fire;

    // Bit 2 = left, bit 1 = centre, bit 0 = right.
    assign adc_arr[2] = adc_l;
    assign adc_arr[1] = adc_c;
    assign adc_arr[0] = adc_r;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [ADC_W:0] sample_ext;
            assign sample_ext = {1'b0, adc_arr[gi]};
            // Inside the band the previous decision is held.
            assign cls_d[gi] = (sample_ext >= HI_LVL) ? 1'b1 :
                               ((sample_ext < LO_LVL) ? 1'b0 : cls_q[gi]);
        end
    endgenerate

    // Run-length of the candidate pattern; acc only on the sample that
    // first brings the run up to DEBOUNCE, not while it stays saturated.
    always_comb begin
        same_pat = (cls_d == cand_q);
        cnt_d    = 4'd1;
        if (same_pat) begin
            cnt_d = (cnt_q == DB_LVL) ? cnt_q : cnt_q + 4'd1;
        end
        fire = (cnt_d == DB_LVL) && !(same_pat && (cnt_q == DB_LVL));
    end

    // Classifier and debounce state, updated only on sample strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q      <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
            acc_q      <= 1'b0;
        end else if (clear) begin
            cls_q      <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            accepted_q <= '0;
            acc_q      <= 1'b0;
        end else begin
            acc_q <= 1'b0;
            if (sample_valid) begin
                cls_q  <= cls_d;
                cand_q <= cls_d;
                cnt_q  <= cnt_d;
                if (fire) begin
                    accepted_q <= cls_d;
                    acc_q      <= 1'b1;
                end
            end
        end
    end

    assign accepted = accepted_q;
    assign acc      = acc_q;

endmodule

// File: rtl/line_follow_decider.sv
// Line-follower decision stage: debounced sensor pattern in, turn command,
// node pulse/count and lost flag out. All outputs come straight from flops.
module line_follow_decider
    import sb_pkg::*;
#(
    parameter int ADC_W        = 12,
    parameter int THRESH       = 1500,
    parameter int HYST         = 64,
    parameter int DEBOUNCE     = 3,
    parameter int NODE_HOLD    = 8,
    parameter int SEARCH_LIMIT = 200
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] adc_l,
    input  logic [ADC_W-1:0] adc_c,
    input  logic [ADC_W-1:0] adc_r,
    output logic [2:0]       turn,
    output logic             node_pulse,
    output logic [7:0]       node_count,
    output logic             lost
);

    localparam int HOLD_W   = $clog2(NODE_HOLD + 1);
    localparam int SEARCH_W = $clog2(SEARCH_LIMIT + 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(NODE_HOLD);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_LIMIT);

    logic [2:0]          accepted;
    logic                acc;
    logic                debounce_clear;
    fsm_state_t          state_q;
    logic [2:0]          turn_q;
    logic                node_pulse_q;
    logic [7:0]          node_count_q;
    logic                lost_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [SEARCH_W-1:0] search_q;
    logic [SEARCH_W-1:0] search_d;

    // Dropping enable also discards any sample arriving in the same cycle.
    assign debounce_clear = ~enable;

    line_sensor_debounce #(
        .ADC_W    (ADC_W),
        .THRESH   (THRESH),
        .HYST     (HYST),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk          (clk_50),
        .reset        (reset),
        .clear        (debounce_clear),
        .sample_valid (sample_valid),
        .adc_l        (adc_l),
        .adc_c        (adc_c),
        .adc_r        (adc_r),
        .accepted     (accepted),
        .acc          (acc)
    );

    assign hold_d   = hold_q + 1'b1;
    assign search_d = search_q + 1'b1;

    // Decision FSM with registered turn, node and lost outputs.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            turn_q       <= TURN_STOP;
            node_pulse_q <= 1'b0;
            node_count_q <= '0;
            lost_q       <= 1'b0;
            hold_q       <= '0;
            search_q     <= '0;
        end else begin
            node_pulse_q <= 1'b0;
            if (!enable) begin
                state_q  <= ST_IDLE;
                turn_q   <= TURN_STOP;
                lost_q   <= 1'b0;
                hold_q   <= '0;
                search_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q      <= ST_TRACK;
                        turn_q       <= TURN_STOP;
                        node_count_q <= '0;
                    end
                    ST_TRACK: begin
                        if (acc) begin
                            if (accepted == 3'b111) begin
                                state_q      <= ST_NODE;
                                turn_q       <= TURN_FWD;
                                node_pulse_q <= 1'b1;
                                hold_q       <= '0;
                                if (node_count_q != 8'hFF) begin
                                    node_count_q <= node_count_q + 8'd1;
                                end
                            end else if (accepted == 3'b000) begin
                                state_q  <= ST_SEARCH;
                                turn_q   <= TURN_EXTREME;
                                search_q <= '0;
                            end else begin
                                turn_q <= track_turn(accepted, turn_q);
                            end
                        end
                    end
                    ST_NODE: begin
                        // Drive straight through the junction; patterns seen
                        // meanwhile are deliberately ignored.
                        if (sample_valid) begin
                            if (hold_d == HOLD_LAST) begin
                                state_q <= ST_TRACK;
                                hold_q  <= '0;
                            end else begin
                                hold_q <= hold_d;
                            end
                        end
                    end
                    ST_SEARCH: begin
                        // Reacquiring the line beats a coincident timeout.
                        if (acc && accepted[1]) begin
                            state_q  <= ST_TRACK;
                            turn_q   <= TURN_FWD;
                            search_q <= '0;
                        end else if (sample_valid) begin
                            search_q <= search_d;
                            if (search_d == SEARCH_LAST) begin
                                state_q <= ST_HALT;
                                turn_q  <= TURN_STOP;
                                lost_q  <= 1'b1;
                            end
                        end
                    end
                    ST_HALT: begin
                        turn_q <= TURN_STOP;
                        lost_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        turn_q  <= TURN_STOP;
                    end
                endcase
            end
        end
    end

    assign turn       = turn_q;
    assign node_pulse = node_pulse_q;
    assign node_count = node_count_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_line_follow_decider.sv
// Self-checking bench for line_follow_decider: expected outputs are queued
// as each sensor strobe is driven and compared once the FSM has reacted.
`timescale 1ns/1ps
module tb_line_follow_decider;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [11:0] adc_l;
    logic [11:0] adc_c;
    logic [11:0] adc_r;
    logic [2:0]  turn;
    logic        node_pulse;
    logic [7:0]  node_count;
    logic        lost;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] turn;
        logic       pulse;
        logic [7:0] cnt;
        logic       lost;
    } exp_t;

    exp_t sb_q[$];

    always #10 clk_50 = ~clk_50;

    line_follow_decider dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .adc_l        (adc_l),
        .adc_c        (adc_c),
        .adc_r        (adc_r),
        .turn         (turn),
        .node_pulse   (node_pulse),
        .node_count   (node_count),
        .lost         (lost)
    );

    function automatic logic [11:0] lvl(input logic b);
        return b ? 12'd3000 : 12'd200;
    endfunction

    // One strobe; returns at the falling edge after the FSM has reacted.
    task automatic strobe(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
        @(negedge clk_50);
        sample_valid = 1'b1;
        adc_l = l;
        adc_c = c;
        adc_r = r;
        @(negedge clk_50);
        sample_valid = 1'b0;
        @(negedge clk_50);
    endtask

    task automatic strobe_pat(input logic [2:0] p);
        strobe(lvl(p[2]), lvl(p[1]), lvl(p[0]));
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        adc_l = '0;
        adc_c = '0;
        adc_r = '0;
        repeat (3) @(negedge clk_50);
        n_cmp++;
        if ({turn, node_pulse, node_count, lost} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: turn=%0d pulse=%0b cnt=%0d lost=%0b, want all zero",
                     turn, node_pulse, node_count, lost);
        end
        $display("reset: turn=%0d cnt=%0d lost=%0b", turn, node_count, lost);
        reset = 1'b0;
    endtask

    task automatic test_track_debounce;
        int   pats [21] = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b110,
                            3'b001, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101,
                            3'b100, 3'b100, 3'b100, 3'b011, 3'b011, 3'b011,
                            3'b010, 3'b010, 3'b010};
        int   et [21]   = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 2, 2, 2, 3, 3, 3, 1};
        exp_t e;
        exp_t got;
        enable = 1'b1;
        repeat (2) @(negedge clk_50);
        for (int i = 0; i < 21; i++) begin
            sb_q.push_back({3'(et[i]), 1'b0, 8'd0, 1'b0});
            strobe_pat(3'(pats[i]));
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL track[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("track[%0d]: pattern=%03b turn=%0d", i, 3'(pats[i]), turn);
        end
    endtask

    task automatic test_hysteresis;
        int   cv [18] = '{1430, 1430, 1430, 1530, 1530, 1530, 1570, 1570, 1570,
                          1450, 1450, 1450, 1430, 1430, 1430, 3000, 3000, 3000};
        int   et [18] = '{1, 1, 4, 4, 4, 4, 4, 4, 1, 1, 1, 1, 1, 1, 4, 4, 4, 1};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 18; i++) begin
            sb_q.push_back({3'(et[i]), 1'b0, 8'd0, 1'b0});
            strobe(12'd200, 12'(cv[i]), 12'd200);
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL hyst[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("hyst[%0d]: centre=%0d turn=%0d", i, cv[i], turn);
        end
    endtask

    task automatic test_node;
        int   pats [22] = '{3'b111, 3'b111, 3'b111,
                            3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b011, 3'b011, 3'b011,
                            3'b111, 3'b111, 3'b111,
                            3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b001, 3'b001, 3'b001};
        int   et [22]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3};
        int   ep [22]   = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        int   ec [22]   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 22; i++) begin
            sb_q.push_back({3'(et[i]), 1'(ep[i]), 8'(ec[i]), 1'b0});
            strobe_pat(3'(pats[i]));
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL node[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("node[%0d]: pattern=%03b turn=%0d pulse=%0b cnt=%0d", i, 3'(pats[i]), turn, node_pulse, node_count);
        end
    endtask

    task automatic test_node_saturation;
        exp_t e;
        exp_t got;
        // Two nodes already counted; 298 more brings the total to 300.
        for (int i = 0; i < 298; i++) begin
            repeat (8) strobe_pat(3'b111);
            if (i == 252 || i == 297) begin
                sb_q.push_back({3'd1, 1'b0, 8'd255, 1'b0});
            end
            repeat (3) strobe_pat(3'b010);
            if (i == 252 || i == 297) begin
                e   = sb_q.pop_front();
                got = {turn, node_pulse, node_count, lost};
                n_cmp++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL node_sat[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                             i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
                end
                $display("node_sat[%0d]: cnt=%0d turn=%0d", i, node_count, turn);
            end
        end
    endtask

    task automatic test_search_timeout;
        exp_t e;
        exp_t got;
        for (int i = 0; i < 203; i++) begin
            if (i < 2)        sb_q.push_back({3'd1, 1'b0, 8'd255, 1'b0});
            else if (i < 202) sb_q.push_back({3'd4, 1'b0, 8'd255, 1'b0});
            else              sb_q.push_back({3'd0, 1'b0, 8'd255, 1'b1});
            strobe_pat(3'b000);
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL search[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("search[%0d]: turn=%0d lost=%0b", i, turn, lost);
        end
        enable = 1'b0;
        @(negedge clk_50);
        n_cmp++;
        if ({turn, lost} !== 4'b0000) begin
            n_fail++;
            $display("FAIL halt_exit: turn=%0d lost=%0b, want turn=0 lost=0", turn, lost);
        end
        $display("halt_exit: turn=%0d lost=%0b", turn, lost);
        enable = 1'b1;
        @(negedge clk_50);
        n_cmp++;
        if (node_count !== 8'd0) begin
            n_fail++;
            $display("FAIL count_clear: cnt=%0d, want 0", node_count);
        end
        $display("count_clear: cnt=%0d", node_count);
    endtask

    task automatic test_enable_coincident;
        int   et [5] = '{0, 0, 0, 0, 1};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back({3'(et[i]), 1'b0, 8'd0, 1'b0});
            strobe_pat(3'b010);
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL coinc_pre[%0d]: turn=%0d, want %0d", i, got.turn, e.turn);
            end
            $display("coinc_pre[%0d]: turn=%0d", i, turn);
        end
        @(negedge clk_50);
        sample_valid = 1'b1;
        adc_l = lvl(1'b0);
        adc_c = lvl(1'b1);
        adc_r = lvl(1'b0);
        enable = 1'b0;
        @(negedge clk_50);
        sample_valid = 1'b0;
        n_cmp++;
        if (turn !== 3'd0) begin
            n_fail++;
            $display("FAIL coinc_idle: turn=%0d, want 0", turn);
        end
        $display("coinc_idle: turn=%0d", turn);
        enable = 1'b1;
        repeat (3) @(negedge clk_50);
        for (int i = 2; i < 5; i++) begin
            sb_q.push_back({3'(et[i]), 1'b0, 8'd0, 1'b0});
            strobe_pat(3'b010);
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL coinc_post[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("coinc_post[%0d]: turn=%0d", i, turn);
        end
    endtask

    task automatic test_reset_mid_node;
        exp_t e;
        exp_t got;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({3'd1, (i == 2) ? 1'b1 : 1'b0, (i == 2) ? 8'd1 : 8'd0, 1'b0});
            strobe_pat(3'b111);
            e   = sb_q.pop_front();
            got = {turn, node_pulse, node_count, lost};
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL rst_node[%0d]: turn=%0d pulse=%0b cnt=%0d lost=%0b, want turn=%0d pulse=%0b cnt=%0d lost=%0b",
                         i, got.turn, got.pulse, got.cnt, got.lost, e.turn, e.pulse, e.cnt, e.lost);
            end
            $display("rst_node[%0d]: turn=%0d pulse=%0b cnt=%0d", i, turn, node_pulse, node_count);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({turn, node_pulse, node_count} !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_async: turn=%0d pulse=%0b cnt=%0d, want all zero", turn, node_pulse, node_count);
        end
        $display("rst_async: turn=%0d pulse=%0b cnt=%0d", turn, node_pulse, node_count);
        @(negedge clk_50);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50);
            n_cmp++;
            if ({node_pulse, node_count} !== 9'd0) begin
                n_fail++;
                $display("FAIL rst_release[%0d]: pulse=%0b cnt=%0d, want 0/0", i, node_pulse, node_count);
            end
            $display("rst_release[%0d]: pulse=%0b cnt=%0d", i, node_pulse, node_count);
        end
    endtask

    initial begin
        test_reset();
        test_track_debounce();
        test_hysteresis();
        test_node();
        test_node_saturation();
        test_search_timeout();
        test_enable_coincident();
        test_reset_mid_node();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded 5 ms, want completion");
        $fatal(1, "timeout");
    end

endmodule
